// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns PCF, a single-outstanding imem handshake and the IF/ID register.
// A response that cannot be consumed is parked in a one-entry hold buffer until decode accepts it.
module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCen_i,
    input  logic             Fen_i,
    input  logic             Frst_i,
    input  logic [1:0]       PCSrcE_i,
    input  logic [WIDTH-1:0] PCTargetE_i,
    input  logic [WIDTH-1:0] ALUResultE_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    input  logic             imem_valid_i,
    output logic [31:0]      InstrD_o,
    output logic [WIDTH-1:0] PCD_o,
    output logic [WIDTH-1:0] PCPlus4D_o,
    output logic             ValidD_o,
    output logic             FetchStall_o
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pcf;
    logic [31:0]      r_buf;
    logic [31:0]      r_instrd;
    logic [WIDTH-1:0] r_pcd, r_pc4d;
    logic             r_validd;

    logic             w_redirect, w_avail, w_accept, w_capture;
    logic [WIDTH-1:0] w_target, w_pcf_plus4;
    logic [31:0]      w_instr;

    assign w_redirect  = (PCSrcE_i == 2'b01) || (PCSrcE_i == 2'b10);
    assign w_target    = (PCSrcE_i == 2'b01) ? PCTargetE_i : (ALUResultE_i & ~WIDTH'(1));
    assign w_pcf_plus4 = r_pcf + WIDTH'(4);

    assign w_avail  = ((r_state == S_WAIT) && imem_valid_i) || (r_state == S_HOLD);
    assign w_instr  = (r_state == S_HOLD) ? r_buf : imem_rdata_i;
    assign w_accept = w_avail && Fen_i && PCen_i && !w_redirect;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            S_ISSUE: w_state_nxt = w_redirect ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (w_redirect) begin
                    w_state_nxt = imem_valid_i ? S_ISSUE : S_DROP;
                end else if (imem_valid_i) begin
                    if (w_accept) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                    end
                end
            end
            S_HOLD: if (w_redirect || w_accept) w_state_nxt = S_ISSUE;
            // The in-flight response belongs to a squashed PC; swallow it before re-issuing.
            S_DROP: if (imem_valid_i) w_state_nxt = S_ISSUE;
            default: w_state_nxt = S_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ISSUE;
            r_pcf   <= RESET_PC;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect)    r_pcf <= w_target;
            else if (w_accept) r_pcf <= w_pcf_plus4;
            if (w_redirect)     r_buf <= '0;
            else if (w_capture) r_buf <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || Frst_i || w_redirect) begin
            r_instrd <= NOP_INSTR;
            r_pcd    <= '0;
            r_pc4d   <= '0;
            r_validd <= 1'b0;
        end else if (Fen_i) begin
            if (w_accept) begin
                r_instrd <= w_instr;
                r_pcd    <= r_pcf;
                r_pc4d   <= w_pcf_plus4;
                r_validd <= 1'b1;
            end else begin
                r_instrd <= NOP_INSTR;
                r_pcd    <= '0;
                r_pc4d   <= '0;
                r_validd <= 1'b0;
            end
        end
    end

    assign imem_req_o   = (r_state == S_ISSUE) && !rst;
    assign imem_addr_o  = r_pcf;
    assign FetchStall_o = Fen_i && !w_avail;
    assign InstrD_o     = r_instrd;
    assign PCD_o        = r_pcd;
    assign PCPlus4D_o   = r_pc4d;
    assign ValidD_o     = r_validd;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked against
// a transaction-level model of the fetch queue and a variable-latency memory.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCen_i = 1'b1, Fen_i = 1'b1, Frst_i = 1'b0;
    logic [1:0]  PCSrcE_i = 2'b00;
    logic [31:0] PCTargetE_i = '0, ALUResultE_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_valid_i = 1'b0;
    logic [31:0] InstrD_o, PCD_o, PCPlus4D_o;
    logic        ValidD_o, FetchStall_o;

    fetch_stage dut (
        .clk(clk), .rst(rst), .PCen_i(PCen_i), .Fen_i(Fen_i), .Frst_i(Frst_i),
        .PCSrcE_i(PCSrcE_i), .PCTargetE_i(PCTargetE_i), .ALUResultE_i(ALUResultE_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .imem_valid_i(imem_valid_i), .InstrD_o(InstrD_o), .PCD_o(PCD_o),
        .PCPlus4D_o(PCPlus4D_o), .ValidD_o(ValidD_o), .FetchStall_o(FetchStall_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return a ^ 32'h5A5A_0013;
    endfunction

    // Model: fetch PC, whether a request is in flight, whether it is squashed,
    // and whether a returned instruction is parked waiting for decode.
    logic [31:0] m_pc = '0, m_buf = '0;
    bit          m_inflight = 0, m_stale = 0, m_have = 0;
    logic [31:0] e_instr = NOP, e_pcd = '0, e_pc4 = '0;
    logic        e_vld = 1'b0;
    // Memory: one pending request with a countdown.
    bit          mp_pend = 0;
    int          mp_cnt = 0, lat = 1;
    logic [31:0] mp_addr = '0;

    function automatic bit m_issuing();
        return !m_inflight && !m_have;
    endfunction

    task automatic cycle();
        bit redir, avail, acc, issuing;
        logic [31:0] tgt, instr;
        #1;
        redir   = (PCSrcE_i == 2'b01) || (PCSrcE_i == 2'b10);
        tgt     = (PCSrcE_i == 2'b01) ? PCTargetE_i : {ALUResultE_i[31:1], 1'b0};
        issuing = m_issuing();
        avail   = (m_inflight && !m_stale && imem_valid_i) || m_have;
        instr   = m_have ? m_buf : imem_rdata_i;
        acc     = avail && Fen_i && PCen_i && !redir;
        if (!rst) begin
            chk("req", imem_req_o, issuing);
            chk("stall", FetchStall_o, Fen_i && !avail);
            if (issuing) begin
                chk("addr", imem_addr_o, m_pc);
                chk("one_outstanding", mp_pend, 0);
                mp_pend = 1; mp_addr = m_pc; mp_cnt = lat;
            end
            if (imem_valid_i && m_inflight && !m_stale) chk("addr_hold", imem_addr_o, mp_addr);
        end
        if (rst) begin
            m_pc = '0; m_inflight = 0; m_stale = 0; m_have = 0; m_buf = '0;
            e_instr = NOP; e_pcd = '0; e_pc4 = '0; e_vld = 0;
        end else begin
            if (Frst_i || redir) begin
                e_instr = NOP; e_pcd = '0; e_pc4 = '0; e_vld = 0;
            end else if (Fen_i) begin
                if (acc) begin
                    e_instr = instr; e_pcd = m_pc; e_pc4 = m_pc + 32'd4; e_vld = 1;
                end else begin
                    e_instr = NOP; e_pcd = '0; e_pc4 = '0; e_vld = 0;
                end
            end
            if (m_have && (acc || redir)) m_have = 0;
            if (issuing) begin
                m_inflight = 1; m_stale = redir;
            end else if (m_inflight && imem_valid_i) begin
                if (!m_stale && !acc && !redir) begin
                    m_have = 1; m_buf = imem_rdata_i;
                end
                m_inflight = 0; m_stale = 0;
            end else if (m_inflight && redir) begin
                m_stale = 1;
            end
            if (redir)    m_pc = tgt;
            else if (acc) m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        chk("InstrD", InstrD_o, e_instr);
        chk("PCD", PCD_o, e_pcd);
        chk("PCPlus4D", PCPlus4D_o, e_pc4);
        chk("ValidD", ValidD_o, e_vld);
        imem_valid_i = 1'b0;
        imem_rdata_i = $urandom;
        if (rst) begin
            mp_pend = 0;
        end else if (mp_pend) begin
            mp_cnt--;
            if (mp_cnt == 0) begin
                imem_valid_i = 1'b1;
                imem_rdata_i = mem_word(mp_addr);
                mp_pend = 0;
            end
        end
    endtask

    initial begin
        // Reset, then two in-order fetches with 1-cycle memory
        cycle(); cycle();
        rst = 0; lat = 1;
        cycle(); cycle();
        chk("t1_instr", InstrD_o, 32'h0050_0093);
        chk("t1_pcd", PCD_o, 32'h0);
        chk("t1_vld", ValidD_o, 1'b1);
        cycle(); cycle();
        chk("t1_instr2", InstrD_o, 32'h00A0_0113);
        chk("t1_pc4", PCPlus4D_o, 32'h8);

        // Decode stalled while the response comes back
        Fen_i = 0;
        repeat (3) cycle();
        chk("t2_hold_pcd", PCD_o, 32'h4);
        chk("t2_no_req", imem_req_o, 1'b0);
        Fen_i = 1;
        cycle();
        chk("t2_pcd", PCD_o, 32'h8);
        chk("t2_instr", InstrD_o, mem_word(32'h8));
        chk("t2_next_addr", imem_addr_o, 32'hC);

        // Branch redirect while waiting on a slow response
        lat = 3;
        cycle();
        PCSrcE_i = 2'b01; PCTargetE_i = 32'h100;
        cycle();
        PCSrcE_i = 2'b00;
        chk("t3_bubble_v", ValidD_o, 1'b0);
        chk("t3_bubble_i", InstrD_o, NOP);
        for (int i = 0; i < 10 && !m_issuing(); i++) cycle();
        chk("t3_addr", imem_addr_o, 32'h100);
        chk("t3_req", imem_req_o, 1'b1);

        // jalr redirect coincident with the response
        lat = 1;
        cycle();
        chk("t4_valid_now", imem_valid_i, 1'b1);
        PCSrcE_i = 2'b10; ALUResultE_i = 32'h203;
        cycle();
        PCSrcE_i = 2'b00;
        chk("t4_bubble", ValidD_o, 1'b0);
        chk("t4_addr", imem_addr_o, 32'h202);

        // Flush beats stall
        cycle(); cycle();
        chk("t5_pre_vld", ValidD_o, 1'b1);
        Frst_i = 1; Fen_i = 0;
        cycle();
        Frst_i = 0; Fen_i = 1;
        chk("t5_flush_v", ValidD_o, 1'b0);
        chk("t5_flush_i", InstrD_o, NOP);
        chk("t5_pcf", imem_addr_o, 32'h206);
        cycle();

        // PC wrap, then reset during WAIT
        PCSrcE_i = 2'b01; PCTargetE_i = 32'hFFFF_FFFC;
        cycle();
        PCSrcE_i = 2'b00;
        for (int i = 0; i < 20 && !(ValidD_o && PCD_o == 32'hFFFF_FFFC); i++) cycle();
        chk("t6_pcd", PCD_o, 32'hFFFF_FFFC);
        chk("t6_pc4", PCPlus4D_o, 32'h0);
        chk("t6_addr", imem_addr_o, 32'h0);
        lat = 2;
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk("t6_rst_i", InstrD_o, NOP);
        chk("t6_rst_v", ValidD_o, 1'b0);
        chk("t6_rst_pcd", PCD_o, 32'h0);
        chk("t6_rst_addr", imem_addr_o, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            lat    = $urandom_range(1, 3);
            Fen_i  = ($urandom_range(0, 99) < 80);
            PCen_i = ($urandom_range(0, 99) < 85);
            Frst_i = ($urandom_range(0, 99) < 5);
            rst    = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 99);
            PCSrcE_i     = (r < 88) ? 2'b00 : (r < 93) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
            PCTargetE_i  = $urandom;
            ALUResultE_i = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
